// File: rtl/unpack_10x_11byte_if.sv
// Byte-stream and frame/error bus between the 8b/10b decoder and the 88-bit word consumer.
interface unpack_10x_11byte_if #(
  parameter int NUM_BYTES = 11
);
  logic                   valid_in;
  logic                   k_in;
  logic [7:0]             data_in;
  logic                   valid_out;
  logic [8*NUM_BYTES-1:0] data_out;
  logic                   err_short;
  logic                   err_long;
  logic                   err_kchar;

  modport master (
    output valid_in, k_in, data_in,
    input  valid_out, data_out, err_short, err_long, err_kchar
  );

  modport slave (
    input  valid_in, k_in, data_in,
    output valid_out, data_out, err_short, err_long, err_kchar
  );
endinterface

// File: rtl/unpack_10x_11byte.sv
// Deframer: K-delimited 11-byte frames into 88-bit words, with runt/overrun/bad-K flags.
// Optional saturating error counter enabled by UNPACK_ERR_CNT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// HUNT    | after reset, waiting for the first K; data bytes ignored
// IDLE    | between frames; K bytes are idle fill
// COLLECT | storing data bytes 1..10 of a frame
// END     | 11 bytes taken; the next byte must be K
// DISCARD | overrun seen; dropping data until the next K
module unpack_10x_11byte #(
  parameter logic [7:0] K_CHAR    = 8'hBC,
  parameter int         NUM_BYTES = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  unpack_10x_11byte_if.slave   bus
`ifdef UNPACK_ERR_CNT_EN
  ,
  input  logic                 err_cnt_clr,
  output logic [15:0]          err_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_IDLE,
    ST_COLLECT,
    ST_END,
    ST_DISCARD
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  state_t                     state;
  logic [3:0]                 byte_cnt;
  logic [8*(NUM_BYTES-1)-1:0] asm_q;
  logic [8*NUM_BYTES-1:0]     data_out_q;
  logic                       valid_q;
  logic                       err_short_q;
  logic                       err_long_q;
  logic                       err_kchar_q;
  logic                       k_byte;
  logic                       d_byte;

  assign k_byte = bus.valid_in & bus.k_in;
  assign d_byte = bus.valid_in & ~bus.k_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HUNT;
      byte_cnt    <= '0;
      asm_q       <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_kchar_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_kchar_q <= k_byte && (bus.data_in != K_CHAR);
      case (state)
        ST_HUNT: begin
          if (k_byte) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (d_byte) begin
            asm_q[7:0] <= bus.data_in;
            byte_cnt   <= 4'd1;
            state      <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (k_byte) begin
            // Runt: the K closes the broken frame and also opens the next one.
            err_short_q <= 1'b1;
            byte_cnt    <= '0;
            state       <= ST_IDLE;
          end else if (d_byte) begin
            if (byte_cnt == LAST_IDX) begin
              data_out_q <= {bus.data_in, asm_q};
              valid_q    <= 1'b1;
              byte_cnt   <= '0;
              state      <= ST_END;
            end else begin
              for (int i = 1; i < NUM_BYTES - 1; i++) begin
                if (byte_cnt == 4'(i)) asm_q[8*i +: 8] <= bus.data_in;
              end
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        ST_END: begin
          if (k_byte) begin
            state <= ST_IDLE;
          end else if (d_byte) begin
            err_long_q <= 1'b1;
            state      <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (k_byte) state <= ST_IDLE;
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.err_short = err_short_q;
  assign bus.err_long  = err_long_q;
  assign bus.err_kchar = err_kchar_q;

`ifdef UNPACK_ERR_CNT_EN
  logic [1:0]  ev_num;
  logic [16:0] cnt_sum;
  logic [15:0] err_cnt_q;

  // Counts the registered pulses, so runt + bad-K in one cycle adds two.
  assign ev_num  = 2'(err_short_q) + 2'(err_long_q) + 2'(err_kchar_q);
  assign cnt_sum = {1'b0, err_cnt_q} + {15'b0, ev_num};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_cnt_clr) begin
      err_cnt_q <= {14'b0, ev_num};
    end else if (cnt_sum[16]) begin
      err_cnt_q <= 16'hFFFF;
    end else begin
      err_cnt_q <= cnt_sum[15:0];
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_unpack_10x_11byte.sv
// Self-checking bench for unpack_10x_11byte: frame-level reference model plus directed and random traffic.
module tb_unpack_10x_11byte;
  localparam logic [7:0] K_CHAR = 8'hBC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unpack_10x_11byte_if #(.NUM_BYTES(11)) bus ();

`ifdef UNPACK_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] err_cnt;
  int          exp_cnt = 0;
`endif

  unpack_10x_11byte #(.K_CHAR(K_CHAR), .NUM_BYTES(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UNPACK_ERR_CNT_EN
    ,
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: frame = run of data bytes between K bytes.
  bit          seen_k = 0;
  int          ndata = 0;
  logic [7:0]  frame [11];
  logic        exp_valid = 0, exp_short = 0, exp_long = 0, exp_kchar = 0;
  logic [87:0] exp_data = '0;

  int n_valid = 0, n_short = 0, n_long = 0, n_kchar = 0;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    seen_k = 0; ndata = 0;
    exp_valid = 0; exp_short = 0; exp_long = 0; exp_kchar = 0;
    exp_data = '0;
`ifdef UNPACK_ERR_CNT_EN
    exp_cnt = 0;
`endif
  endtask

  task automatic model_edge(input logic v, input logic k, input logic [7:0] d, input logic clr);
`ifdef UNPACK_ERR_CNT_EN
    int s;
    s = int'(exp_short) + int'(exp_long) + int'(exp_kchar);
    if (clr) exp_cnt = s;
    else exp_cnt = (exp_cnt + s > 65535) ? 65535 : exp_cnt + s;
`endif
    exp_valid = 0; exp_short = 0; exp_long = 0; exp_kchar = 0;
    if (v && k) begin
      exp_kchar = (d != K_CHAR);
      exp_short = seen_k && ndata > 0 && ndata < 11;
      seen_k = 1;
      ndata = 0;
    end else if (v && seen_k && ndata < 12) begin
      if (ndata < 11) frame[ndata] = d;
      ndata++;
      if (ndata == 11) begin
        exp_valid = 1;
        for (int i = 0; i < 11; i++) exp_data[8*i +: 8] = frame[i];
      end
      if (ndata == 12) exp_long = 1;
    end
  endtask

  always @(negedge clk) begin
    chk("valid_out", 88'(bus.valid_out), 88'(exp_valid));
    chk("err_short", 88'(bus.err_short), 88'(exp_short));
    chk("err_long",  88'(bus.err_long),  88'(exp_long));
    chk("err_kchar", 88'(bus.err_kchar), 88'(exp_kchar));
    chk("data_out",  bus.data_out, exp_data);
`ifdef UNPACK_ERR_CNT_EN
    chk("err_cnt", 88'(err_cnt), 88'(exp_cnt));
`endif
    if (bus.valid_out === 1'b1) n_valid++;
    if (bus.err_short === 1'b1) n_short++;
    if (bus.err_long === 1'b1) n_long++;
    if (bus.err_kchar === 1'b1) n_kchar++;
  end

  task automatic step(input logic v, input logic k, input logic [7:0] d);
    logic clr;
    clr = 1'b0;
    bus.valid_in = v; bus.k_in = k; bus.data_in = d;
`ifdef UNPACK_ERR_CNT_EN
    clr = ($urandom_range(0, 29) == 0);
    err_cnt_clr = clr;
`endif
    @(posedge clk);
    model_edge(v, k, d, clr);
    cyc++;
    #1;
  endtask

  // Valid pattern: 8 of every 10 clocks carry a byte.
  task automatic send(input logic k, input logic [7:0] d);
    while (cyc % 10 >= 8) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    step(1'b1, k, d);
  endtask

  task automatic send_k();
    send(1'b1, K_CHAR);
  endtask

  task automatic send_run(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) send(1'b0, first + 8'(i));
  endtask

  task automatic do_reset();
    bus.valid_in = 0; bus.k_in = 0; bus.data_in = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
  endtask

  int v0, s0, l0, kc0;
  task automatic snap();
    v0 = n_valid; s0 = n_short; l0 = n_long; kc0 = n_kchar;
  endtask

  initial begin
    bus.valid_in = 0; bus.k_in = 0; bus.data_in = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset data_out", bus.data_out, 88'h0);
    chk("reset valid_out", 88'(bus.valid_out), 88'h0);

    // Directed 1: clean frame with gapped valids
    snap();
    send_k(); send_k(); send_run(8'h00, 11); send_k();
    step(1'b0, 1'b0, 8'h00);
    chk("t1 data_out", bus.data_out, 88'h0A090807060504030201_00);
    chk("t1 valid pulses", 88'(n_valid - v0), 88'd1);
    chk("t1 error pulses", 88'((n_short - s0) + (n_long - l0) + (n_kchar - kc0)), 88'd0);

    // Directed 2: mid-frame start after reset
    do_reset();
    snap();
    send_run(8'h05, 6); send_k(); send_run(8'h10, 11); send_k();
    step(1'b0, 1'b0, 8'h00);
    chk("t2 valid pulses", 88'(n_valid - v0), 88'd1);
    chk("t2 byte0", 88'(bus.data_out[7:0]), 88'h10);
    chk("t2 byte10", 88'(bus.data_out[87:80]), 88'h1A);

    // Directed 3: runt
    snap();
    send_k(); send_run(8'hE0, 5); send_k();
    step(1'b0, 1'b0, 8'h00);
    chk("t3 short pulses", 88'(n_short - s0), 88'd1);
    chk("t3 valid pulses", 88'(n_valid - v0), 88'd0);
    chk("t3 data_out held", bus.data_out, 88'h1A191817161514131211_10);

    // Directed 4: overrun then good frame
    snap();
    send_k(); send_run(8'h20, 12); send_k(); send_run(8'h30, 11); send_k();
    step(1'b0, 1'b0, 8'h00);
    chk("t4 valid pulses", 88'(n_valid - v0), 88'd2);
    chk("t4 long pulses", 88'(n_long - l0), 88'd1);
    chk("t4 data_out", bus.data_out, 88'h3A393837363534333231_30);

    // Directed 5: bad K in idle
    snap();
    send(1'b1, 8'h7C); send_run(8'h40, 11); send_k();
    step(1'b0, 1'b0, 8'h00);
    chk("t5 kchar pulses", 88'(n_kchar - kc0), 88'd1);
    chk("t5 valid pulses", 88'(n_valid - v0), 88'd1);
    chk("t5 data_out", bus.data_out, 88'h4A494847464544434241_40);

    // Directed 6: reset mid-frame
    send_k(); send_run(8'h50, 6);
    do_reset();
`ifdef UNPACK_ERR_CNT_EN
    chk("t6 err_cnt after rst", 88'(err_cnt), 88'd0);
`endif
    snap();
    send_k(); send_run(8'h60, 11); send_k();
    step(1'b0, 1'b0, 8'h00);
    chk("t6 valid pulses", 88'(n_valid - v0), 88'd1);
    chk("t6 byte0", 88'(bus.data_out[7:0]), 88'h60);

    // Random traffic; per-cycle checking is done by the compare process.
    for (int seg = 0; seg < 400; seg++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: len = 11;
        4, 5:       len = $urandom_range(1, 10);
        6, 7:       len = $urandom_range(12, 15);
        default:    len = 0;
      endcase
      for (int i = 0; i < len; i++) begin
        send(1'b0, 8'($urandom));
        if ($urandom_range(0, 7) == 0) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      if ($urandom_range(0, 9) == 0) send(1'b1, 8'($urandom));
      else send_k();
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end
endmodule
